dae_res_collector: RTL and testbench

// - Downstream neighbour of the DAE PE: gathers the registered PE result stream into a small FIFO.
// - Presents results to the store/access side over valid/ready.
// - Back-pressures the PE issue logic through stall_o so that no in-flight result is ever lost.
// - Counts results per kernel invocation and pulses done_o when all have been handed off.

---
 rtl/dae_res_collector_pkg.sv | 8 +
 rtl/dae_res_fifo.sv | 60 ++++++
 rtl/dae_res_collector.sv | 115 +++++++++++
 tb/tb_dae_res_collector.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dae_res_collector_pkg.sv
// Shared types and constants for the DAE result collector.
// Pure declarations: no logic, no latency, no flow control.
package dae_res_collector_pkg;
  localparam int PE_N_BITS      = 32;
  localparam int RES_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {RC_IDLE, RC_RUN, RC_DRAIN, RC_DONE} res_coll_state_t;
endpackage

// File: rtl/dae_res_fifo.sv
// Synchronous FIFO for PE results; a push is visible at the head one cycle later.
// No internal backpressure: the producer must never push when full (guaranteed by credits upstream).
module dae_res_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  output logic [W-1:0]     data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [OCC_W-1:0] occ_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push_i && !pop_i) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!push_i && pop_i) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (occ_q == OCC_W'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign occ_o   = occ_q;
endmodule

// File: rtl/dae_res_collector.sv
// Collects registered PE results into a FIFO and hands them off over valid/ready; fire->valid is PE_LATENCY+1.
// Backpressure: stall_o holds PE issue whenever queued plus in-flight results would exceed the FIFO.
module dae_res_collector
  import dae_res_collector_pkg::*;
#(
  parameter int N_BITS     = PE_N_BITS,
  parameter int DEPTH      = RES_FIFO_DEPTH,
  parameter int PE_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  n_res_i,
  input  logic              fire_i,
  input  logic [N_BITS-1:0] pe_res_i,
  output logic              stall_o,
  output logic [N_BITS-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  res_cnt_o
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  res_coll_state_t       state_q, state_d;
  logic [CNT_W-1:0]      n_res_q, n_res_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]      res_cnt_q, res_cnt_d;
  logic [PE_LATENCY-1:0] vpipe_q, vpipe_d;
  logic [OCC_W-1:0]      occ;
  logic [OCC_W:0]        inflight, credit_used;
  logic                  fifo_empty, fifo_full;
  logic                  accept, push, pop;

  // Credits count both queued entries and results still inside the PE pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PE_LATENCY; i++) inflight = inflight + (OCC_W+1)'(vpipe_q[i]);
    credit_used = (OCC_W+1)'(occ) + inflight;
    stall_o     = (state_q != RC_RUN) || (credit_used >= (OCC_W+1)'(DEPTH));
    accept      = fire_i && !stall_o;
    vpipe_d     = PE_LATENCY'({vpipe_q, accept});
    push        = vpipe_q[PE_LATENCY-1];
    pop         = !fifo_empty && out_ready_i;
  end

  always_comb begin
    state_d     = state_q;
    n_res_d     = n_res_q;
    issue_cnt_d = issue_cnt_q;
    res_cnt_d   = res_cnt_q + CNT_W'(pop);
    unique case (state_q)
      RC_IDLE: begin
        if (start_i) begin
          n_res_d     = n_res_i;
          issue_cnt_d = '0;
          res_cnt_d   = '0;
          state_d     = (n_res_i != '0) ? RC_RUN : RC_DONE;
        end
      end
      RC_RUN: begin
        if (accept) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (issue_cnt_d == n_res_q) state_d = RC_DRAIN;
        end
      end
      RC_DRAIN: begin
        if ((res_cnt_q == n_res_q) && fifo_empty && (vpipe_q == '0)) state_d = RC_DONE;
      end
      RC_DONE: state_d = RC_IDLE;
      default: state_d = RC_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= RC_IDLE;
      n_res_q     <= '0;
      issue_cnt_q <= '0;
      res_cnt_q   <= '0;
      vpipe_q     <= '0;
    end else begin
      state_q     <= state_d;
      n_res_q     <= n_res_d;
      issue_cnt_q <= issue_cnt_d;
      res_cnt_q   <= res_cnt_d;
      vpipe_q     <= vpipe_d;
    end
  end

  dae_res_fifo #(
    .W    (N_BITS),
    .DEPTH(DEPTH),
    .OCC_W(OCC_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (push),
    .push_data_i(pe_res_i),
    .pop_i      (pop),
    .data_o     (out_data_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .occ_o      (occ)
  );

  assign out_valid_o = !fifo_empty;
  assign busy_o      = (state_q != RC_IDLE);
  assign done_o      = (state_q == RC_DONE);
  assign res_cnt_o   = res_cnt_q;

  push_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i) push |-> !fifo_full);
endmodule

// File: tb/tb_dae_res_collector.sv
// Bench for dae_res_collector: directed scenarios plus random traffic against a queue-based model.
module tb_dae_res_collector;
  localparam int N_BITS = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_DONE = 3;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              start_i = 1'b0;
  logic [CNT_W-1:0]  n_res_i = '0;
  logic              fire_i = 1'b0;
  logic [N_BITS-1:0] pe_res_i = '0;
  logic              stall_o;
  logic [N_BITS-1:0] out_data_o;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic              busy_o;
  logic              done_o;
  logic [CNT_W-1:0]  res_cnt_o;

  int total = 0;
  int bad   = 0;

  // Reference model: phase, expected count, issued/popped counts, FIFO contents, one pending PE result.
  int                m_ph = PH_IDLE;
  int                m_n = 0, m_iss = 0, m_pop = 0;
  bit                m_pend = 1'b0;
  logic [N_BITS-1:0] m_q[$];
  logic [N_BITS-1:0] seq = 1;
  logic [N_BITS-1:0] got[$];
  int                done_seen = 0;

  dae_res_collector #(
    .N_BITS(N_BITS), .DEPTH(DEPTH), .PE_LATENCY(1), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .n_res_i(n_res_i),
    .fire_i(fire_i), .pe_res_i(pe_res_i), .stall_o(stall_o), .out_data_o(out_data_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o),
    .done_o(done_o), .res_cnt_o(res_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, act, exp_v);
    end
  endtask

  function automatic bit model_stall();
    return (m_ph != PH_RUN) || ((m_q.size() + int'(m_pend)) >= DEPTH);
  endfunction

  task automatic compare_outputs();
    check_val("stall", 64'(stall_o), 64'(model_stall()));
    check_val("valid", 64'(out_valid_o), 64'(m_q.size() != 0));
    check_val("busy", 64'(busy_o), 64'(m_ph != PH_IDLE));
    check_val("done", 64'(done_o), 64'(m_ph == PH_DONE));
    check_val("res_cnt", 64'(res_cnt_o), 64'(m_pop));
    if (m_q.size() != 0) check_val("data", 64'(out_data_o), 64'(m_q[0]));
  endtask

  task automatic model_step();
    bit acc, pop, drained;
    acc     = fire_i && !model_stall();
    pop     = (m_q.size() != 0) && out_ready_i;
    drained = (m_pop == m_n) && (m_q.size() == 0) && !m_pend;
    if (pop) begin
      void'(m_q.pop_front());
      m_pop++;
    end
    case (m_ph)
      PH_IDLE: if (start_i) begin
        m_n   = int'(n_res_i);
        m_iss = 0;
        m_pop = 0;
        m_ph  = (n_res_i != 0) ? PH_RUN : PH_DONE;
      end
      PH_RUN: if (acc) begin
        m_iss++;
        if (m_iss == m_n) m_ph = PH_DRAIN;
      end
      PH_DRAIN: if (drained) m_ph = PH_DONE;
      default: m_ph = PH_IDLE;
    endcase
    if (m_pend) begin
      m_q.push_back(pe_res_i);
      seq++;
    end
    m_pend = acc;
  endtask

  // One clock: drive inputs away from the edge, advance the model, then compare after the edge.
  task automatic cycle(input logic s, input logic [CNT_W-1:0] n, input logic f, input logic r);
    start_i     = s;
    n_res_i     = n;
    fire_i      = f;
    out_ready_i = r;
    pe_res_i    = m_pend ? seq : N_BITS'($urandom);
    if (out_valid_o && out_ready_i) got.push_back(out_data_o);
    if (done_o) done_seen++;
    model_step();
    @(posedge clk_i);
    #2;
    compare_outputs();
  endtask

  task automatic do_reset();
    rst_n_i     = 1'b0;
    start_i     = 1'b0;
    fire_i      = 1'b0;
    out_ready_i = 1'b0;
    #1;
    m_ph = PH_IDLE; m_q.delete(); m_pend = 1'b0; m_pop = 0; m_iss = 0; m_n = 0;
    check_val("rst_stall", 64'(stall_o), 64'(1));
    check_val("rst_valid", 64'(out_valid_o), 64'(0));
    check_val("rst_data", 64'(out_data_o), 64'(0));
    check_val("rst_busy", 64'(busy_o), 64'(0));
    check_val("rst_done", 64'(done_o), 64'(0));
    check_val("rst_cnt", 64'(res_cnt_o), 64'(0));
    @(posedge clk_i);
    #2;
    compare_outputs();
    rst_n_i = 1'b1;
  endtask

  task automatic start_test();
    seq = 1;
    got.delete();
    done_seen = 0;
  endtask

  initial begin
    #2;
    do_reset();

    // n_res=5, continuous fire and ready; fire stays high through DRAIN and IDLE.
    start_test();
    cycle(1'b1, 16'd5, 1'b0, 1'b1);
    repeat (20) cycle(1'b0, 16'd0, 1'b1, 1'b1);
    check_val("t1_count", 64'(got.size()), 64'(5));
    for (int i = 0; i < got.size() && i < 5; i++) check_val("t1_order", 64'(got[i]), 64'(i + 1));
    check_val("t1_done_pulses", 64'(done_seen), 64'(1));
    check_val("t1_issue_cnt", 64'(dut.issue_cnt_q), 64'(5));

    // Zero-length invocation.
    start_test();
    cycle(1'b1, 16'd0, 1'b0, 1'b1);
    check_val("t2_done_now", 64'(done_o), 64'(1));
    repeat (3) cycle(1'b0, 16'd0, 1'b1, 1'b1);
    check_val("t2_done_pulses", 64'(done_seen), 64'(1));
    check_val("t2_no_results", 64'(got.size()), 64'(0));

    // Consumer stalled: exactly DEPTH entries held, then full release.
    start_test();
    cycle(1'b1, 16'd8, 1'b0, 1'b0);
    repeat (8) cycle(1'b0, 16'd0, 1'b1, 1'b0);
    check_val("t3_occ_full", 64'(dut.u_fifo.occ_o), 64'(4));
    check_val("t3_stalled", 64'(stall_o), 64'(1));
    check_val("t3_issue_cnt", 64'(dut.issue_cnt_q), 64'(4));
    repeat (30) cycle(1'b0, 16'd0, 1'b1, 1'b1);
    check_val("t3_count", 64'(got.size()), 64'(8));
    for (int i = 0; i < got.size() && i < 8; i++) check_val("t3_order", 64'(got[i]), 64'(i + 1));
    check_val("t3_done_pulses", 64'(done_seen), 64'(1));

    // Simultaneous push and pop at occupancy 3.
    start_test();
    cycle(1'b1, 16'd6, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 16'd0, 1'b1, 1'b0);
    cycle(1'b0, 16'd0, 1'b0, 1'b1);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    check_val("t4_occ_before", 64'(dut.u_fifo.occ_o), 64'(3));
    cycle(1'b0, 16'd0, 1'b0, 1'b1);
    check_val("t4_occ_same", 64'(dut.u_fifo.occ_o), 64'(3));
    repeat (30) cycle(1'b0, 16'd0, 1'b1, 1'b1);
    check_val("t4_count", 64'(got.size()), 64'(6));
    for (int i = 0; i < got.size() && i < 6; i++) check_val("t4_order", 64'(got[i]), 64'(i + 1));

    // Reset while draining with two entries queued.
    start_test();
    cycle(1'b1, 16'd2, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 16'd0, 1'b1, 1'b0);
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
    check_val("t5_pre_occ", 64'(dut.u_fifo.occ_o), 64'(2));
    check_val("t5_pre_busy", 64'(busy_o), 64'(1));
    do_reset();

    // Random traffic.
    start_test();
    for (int k = 0; k < 600; k++) begin
      cycle(1'($urandom_range(0, 3) == 0), CNT_W'($urandom_range(0, 9)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end
    repeat (40) cycle(1'b0, 16'd0, 1'b0, 1'b1);
    check_val("rand_idle", 64'(busy_o), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
